// File: rtl/req_agent4.sv
// Client-side request agent for the 4-way priority selector: per-client pending counters, grant checking, optional starvation guard.
// Define REQ_AGENT_STARVE_GUARD_EN to build the wait counters and starvation masking.
module req_agent4 #(
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] push,
    input  logic [3:0] gnt,
    output logic [3:0] req,
    output logic       en,
    output logic [3:0] full,
    output logic [3:0] drop,
    output logic       gnt_err,
    output logic [3:0] starve
);

    logic [CNT_W-1:0] cnt [4];
    logic [3:0]       req_raw;
    logic [3:0]       g;
    logic             gnt_onehot;
    logic             legal;

    always_comb begin
        req_raw = '0;
        full    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            req_raw[i] = (cnt[i] != '0);
            full[i]    = (cnt[i] == '1);
        end
    end

`ifdef REQ_AGENT_STARVE_GUARD_EN
    logic [7:0] wait_cnt [4];

    always_comb begin
        starve = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            starve[i] = (wait_cnt[i] == 8'(STARVE_LIMIT));
        end
        // Only starved clients are presented while any client is starved.
        req = (|starve) ? (req_raw & starve) : req_raw;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cnt[i] == '0 || g[i]) begin
                    wait_cnt[i] <= '0;
                end else if (req_raw[i] && wait_cnt[i] != 8'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    always_comb begin
        starve = '0;
        req    = req_raw;
    end
`endif

    always_comb begin
        en         = |req;
        gnt_onehot = (gnt != '0) && ((gnt & (gnt - 4'd1)) == '0);
        legal      = (gnt == '0) || (gnt_onehot && en && ((gnt & req) != '0));
        g          = legal ? gnt : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            drop    <= '0;
            gnt_err <= 1'b0;
        end else begin
            gnt_err <= ~legal;
            for (int unsigned i = 0; i < 4; i++) begin
                case ({push[i], g[i]})
                    2'b10: begin
                        if (full[i]) begin
                            drop[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_req_agent4.sv
// Self-checking bench for req_agent4: directed scenarios plus randomized traffic against a counter-level model.
module tb_req_agent4;

    localparam int CW   = 3;
    localparam int LIM  = 4;
    localparam int MAXC = (1 << CW) - 1;
`ifdef REQ_AGENT_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] push;
    logic [3:0] gnt;
    logic [3:0] req;
    logic       en;
    logic [3:0] full;
    logic [3:0] drop;
    logic       gnt_err;
    logic [3:0] starve;

    req_agent4 #(.CNT_W(CW), .STARVE_LIMIT(LIM)) dut (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .gnt    (gnt),
        .req    (req),
        .en     (en),
        .full   (full),
        .drop   (drop),
        .gnt_err(gnt_err),
        .starve (starve)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_cnt  [4];
    int         m_wait [4];
    logic [3:0] m_drop;
    logic       m_err;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_starve();
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++) s[i] = GUARD && (m_wait[i] == LIM);
        return s;
    endfunction

    function automatic logic [3:0] m_req();
        logic [3:0] r = '0;
        logic [3:0] s = m_starve();
        for (int i = 0; i < 4; i++) r[i] = (m_cnt[i] > 0);
        return (s != 0) ? (r & s) : r;
    endfunction

    function automatic logic [3:0] m_full();
        logic [3:0] f = '0;
        for (int i = 0; i < 4; i++) f[i] = (m_cnt[i] == MAXC);
        return f;
    endfunction

    function automatic bit m_legal(input logic [3:0] gv);
        return (gv == 0) || ($countones(gv) == 1 && (gv & m_req()) != 0);
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_req"},    {4'd0, req},     {4'd0, m_req()});
        check({tag, "_en"},     {7'd0, en},      {7'd0, (m_req() != 0)});
        check({tag, "_full"},   {4'd0, full},    {4'd0, m_full()});
        check({tag, "_drop"},   {4'd0, drop},    {4'd0, m_drop});
        check({tag, "_err"},    {7'd0, gnt_err}, {7'd0, m_err});
        check({tag, "_starve"}, {4'd0, starve},  {4'd0, m_starve()});
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input logic [3:0] p, input logic [3:0] gv, input logic rst, input string tag);
        bit         lg;
        logic [3:0] gg;
        push  = p;
        gnt   = gv;
        reset = rst;
        lg = m_legal(gv);
        gg = lg ? gv : 4'd0;
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = 0;
                m_wait[i] = 0;
            end
            m_drop = '0;
            m_err  = 1'b0;
        end else begin
            m_err = !lg;
            for (int i = 0; i < 4; i++) begin
                if (m_cnt[i] == 0 || gg[i]) m_wait[i] = 0;
                else if (m_wait[i] < LIM)   m_wait[i] = m_wait[i] + 1;
                if (p[i] && !gg[i]) begin
                    if (m_cnt[i] == MAXC) m_drop[i] = 1'b1;
                    else                  m_cnt[i]  = m_cnt[i] + 1;
                end else if (!p[i] && gg[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [3:0] rp;
        logic [3:0] rg;
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_wait[i] = 0;
        end
        m_drop = '0;
        m_err  = 1'b0;
        push   = '0;
        gnt    = '0;
        reset  = 1'b1;
        #1;

        step(4'b0000, 4'b0000, 1'b1, "rst");
        check("rst_req_const", {4'd0, req}, 8'h00);
        check("rst_en_const",  {7'd0, en},  8'h00);

        step(4'b0101, 4'b0000, 1'b0, "push0101");
        check("push0101_req_const", {4'd0, req}, 8'h05);
        check("push0101_en_const",  {7'd0, en},  8'h01);

        // Fill client 2 past capacity, then drain it.
        step(4'b0000, 4'b0000, 1'b1, "rst2");
        for (int k = 1; k <= 8; k++) begin
            step(4'b0100, 4'b0000, 1'b0, "fill");
            if (k == 6) check("full_before_7th", {7'd0, full[2]}, 8'h00);
            if (k == 7) check("full_after_7th",  {7'd0, full[2]}, 8'h01);
            if (k == 7) check("nodrop_7th",      {7'd0, drop[2]}, 8'h00);
        end
        check("drop_after_8th", {7'd0, drop[2]}, 8'h01);
        for (int k = 0; k < 7; k++) step(4'b0000, 4'b0100, 1'b0, "drain");
        check("drain_req2",  {7'd0, req[2]},  8'h00);
        check("drain_full2", {7'd0, full[2]}, 8'h00);
        check("drain_drop2", {7'd0, drop[2]}, 8'h01);

        // Simultaneous push and grant holds the count.
        step(4'b0000, 4'b0000, 1'b1, "rst3");
        step(4'b0010, 4'b0000, 1'b0, "c1load");
        step(4'b0010, 4'b0010, 1'b0, "pushgnt");
        check("pushgnt_req_const", {4'd0, req}, 8'h02);
        step(4'b0000, 4'b0010, 1'b0, "pushgnt_drain");
        check("pushgnt_cnt_was1", {4'd0, req}, 8'h00);

        // Illegal grants.
        step(4'b0000, 4'b0000, 1'b1, "rst4");
        step(4'b1001, 4'b0000, 1'b0, "ill_load");
        step(4'b0000, 4'b1001, 1'b0, "ill_multi");
        check("ill_multi_err", {7'd0, gnt_err}, 8'h01);
        check("ill_multi_req", {4'd0, req},     8'h09);
        step(4'b0000, 4'b0100, 1'b0, "ill_noreq");
        check("ill_noreq_err", {7'd0, gnt_err}, 8'h01);
        step(4'b0000, 4'b0000, 1'b0, "ill_clear");
        check("ill_clear_err", {7'd0, gnt_err}, 8'h00);
        step(4'b0000, 4'b0000, 1'b1, "rst5");
        step(4'b0000, 4'b0001, 1'b0, "ill_noen");
        check("ill_noen_err", {7'd0, gnt_err}, 8'h01);
        step(4'b0000, 4'b0000, 1'b0, "ill_noen_clr");
        check("ill_noen_clr_err", {7'd0, gnt_err}, 8'h00);

`ifdef REQ_AGENT_STARVE_GUARD_EN
        // Client 3 hogs the grants until client 0 starves.
        step(4'b0000, 4'b0000, 1'b1, "rst6");
        step(4'b1001, 4'b0000, 1'b0, "stv_load");
        step(4'b1001, 4'b1000, 1'b0, "stv_hog");
        for (int k = 0; k < 3; k++) begin
            check("stv_not_yet", {4'd0, starve}, 8'h00);
            step(4'b1000, 4'b1000, 1'b0, "stv_hog");
        end
        check("stv_starve0", {4'd0, starve}, 8'h01);
        check("stv_req",     {4'd0, req},    8'h01);
        step(4'b0000, 4'b0001, 1'b0, "stv_serve");
        check("stv_restore_req", {4'd0, req},    8'h09);
        check("stv_restore_stv", {4'd0, starve}, 8'h00);
        for (int k = 0; k < 4; k++) step(4'b1000, 4'b1000, 1'b0, "stv_hog2");
        check("stv_again", {4'd0, starve}, 8'h01);
`else
        step(4'b0000, 4'b0000, 1'b1, "rst6");
        step(4'b1001, 4'b0000, 1'b0, "stv_load");
        for (int k = 0; k < 20; k++) step(4'b1000, 4'b1000, 1'b0, "nostv_hog");
        check("nostv_starve", {4'd0, starve}, 8'h00);
        check("nostv_req",    {4'd0, req},    8'h09);
`endif
        step(4'b1111, 4'b1111, 1'b1, "rst_busy");
        check("rst_busy_req",    {4'd0, req},     8'h00);
        check("rst_busy_en",     {7'd0, en},      8'h00);
        check("rst_busy_full",   {4'd0, full},    8'h00);
        check("rst_busy_drop",   {4'd0, drop},    8'h00);
        check("rst_busy_starve", {4'd0, starve},  8'h00);
        check("rst_busy_err",    {7'd0, gnt_err}, 8'h00);

        // Randomized traffic; pushes are suppressed when the grant is illegal.
        for (int k = 0; k < 600; k++) begin
            rp = 4'($urandom);
            r  = m_req();
            if ($urandom_range(99) < 70) begin
                rg = '0;
                if (r != 0 && $urandom_range(3) != 0) begin
                    do rg = 4'(1 << $urandom_range(3)); while ((rg & r) == 0);
                end
            end else begin
                rg = 4'($urandom);
            end
            if (!m_legal(rg)) rp = '0;
            step(rp, rg, ($urandom_range(199) == 0), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/req_agent4.md
# req_agent4

Client-side request agent for the 4-way priority selector; it drives the selector's `req`/`en` inputs and consumes its one-hot `gnt`. The agent queues request events from four clients in per-client pending counters. It holds `req[i]` high while client i has work and retires one event per grant. It also flags illegal grants and, optionally, breaks starvation of low-priority clients. It sits between the client logic and the selector tree; bit 3 has the highest selector priority.

## Interface
- `CNT_W`, 3: pending-counter width; each client holds up to 2^CNT_W-1 events (7).
- `STARVE_LIMIT`, 15: wait cycles before a client is marked starved; range 1..255.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  4  per-client request-event strobe; one event per asserted bit per cycle.
- `gnt`  in  4  grant from the priority selector; legal values are zero or one-hot.
- `req`  out  4  request vector to the selector.
- `en`  out  1  grant enable to the selector.
- `full`  out  4  client i pending counter at maximum.
- `drop`  out  4  sticky: a push to client i was lost because its counter was full.
- `gnt_err`  out  1  one-cycle pulse: the previous cycle's grant was illegal.
- `starve`  out  4  client i wait counter at STARVE_LIMIT (0 when the feature is compiled out).

## Operation
- State per client: `cnt[i]` (CNT_W bits) and `wait[i]` (8 bits). Shared state: `drop` and the `gnt_err` register.
- `req_raw[i] = (cnt[i] != 0)`. `req` is `req_raw`, or the starvation-masked vector when that feature is compiled in and active. `en = |req`. `full[i] = (cnt[i] == max)`.
- Grant legality: a grant is legal when `gnt == 0`, or when `gnt` is one-hot, `en == 1`, and `req[gnt_index] == 1`. Any other non-zero `gnt` is illegal. An illegal grant is ignored entirely (no counter changes) and `gnt_err` is set for the next cycle.
- Counter update for client i, given legal `g[i]`:
  - push=1, g=0: increment if not full; otherwise hold and set `drop[i]`.
  - push=0, g=1: decrement.
  - push=1, g=1: hold. This applies even when full, and no drop is recorded.
  - push=0, g=0: hold.
- `drop` bits clear only on reset.
- Wait counter:
  - Cleared when `cnt[i] == 0` or on a legal `g[i]`.
  - Otherwise incremented each cycle that `req_raw[i]` is set, saturating at STARVE_LIMIT.
  - `starve[i] = (wait[i] == STARVE_LIMIT)`.
- Reset drives `cnt`, `wait`, `drop` and `gnt_err` to 0. All outputs therefore read 0 the cycle after reset, and in-flight events are discarded. A push or grant coinciding with `reset` is ignored.

## Timing
- All outputs are functions of registered state only, with no combinational input-to-output path. The selector's `gnt` may therefore depend combinationally on `req`/`en`.
- Push-to-request latency: 1 cycle. A push at edge N raises `req[i]` after edge N.
- Grant retirement happens at the same edge it is sampled. With `cnt[i] == 1`, a grant in cycle N drops `req[i]` in cycle N+1.
- `gnt_err` is high for exactly the cycle following the illegal grant. Back-to-back illegal grants keep it high.
- Starvation: `starve[i]` rises STARVE_LIMIT cycles after `req_raw[i]` first rises with no grant to i.

## Configuration
- `REQ_AGENT_STARVE_GUARD_EN` defined:
  - `wait` counters are built and `starve` is live.
  - While any `starve` bit is set, `req = req_raw & starve`. Only starved clients are presented, and among them the selector's fixed priority applies.
  - `en` follows the masked `req`.
- Not defined:
  - No `wait` registers are built; `starve` is tied to 0.
  - `req = req_raw`, giving pure fixed priority.

## Test plan
- Reset, then push=4'b0101 for one cycle with gnt=0 → after one cycle: req=4'b0101, en=1, full=0, drop=0, gnt_err=0.
- Push client 2 eight times with no grants → full[2]=1 after the 7th push; the 8th push sets drop[2]=1. Then gnt=4'b0100 held for 7 cycles → req[2]=0 and full[2]=0. drop[2] stays 1 until reset.
- cnt[1]=1, push=4'b0010 and gnt=4'b0010 in the same cycle → cnt[1] stays 1, req[1] stays 1, drop[1]=0.
- Each of these illegal grants in turn → gnt_err=1 on the next cycle only, counters unchanged:
  - gnt=4'b1001 with req=4'b1001 (multi-hot);
  - gnt=4'b0100 with req[2]=0;
  - gnt=4'b0001 with en=0.
- Guard enabled, STARVE_LIMIT=4: clients 3 and 0 pending, grants always go to client 3, client 3 repushed every cycle → starve[0]=1 four cycles after req[0] rose; req=4'b0001. A grant to 0 clears wait[0] and restores req=4'b1001.
- Reset asserted while cnt=4'b... nonzero and starve[0]=1 → next cycle: req=0, en=0, full=0, drop=0, starve=0, gnt_err=0.
